game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game-flow controller for the Runner design. It owns the IDLE/RUN/PAUSE/OVER state machine and turns keypad start presses, the pause switch and the collision flag from the drawing logic into a single run enable and a world-clear pulse. It also maintains the 4-digit BCD score and the speed level, and drives the buzzer. It replaces the ad-hoc wiring of keycodes and switches straight into the draw and score blocks, and sits between the Keypad/AntiJitter outputs and the draw/display modules.

## Interface
Parameters:
- `START_KEY`, 5'h10: keycode that starts or restarts a game.
- `SCORE_MS`, 100: number of `tick_1ms` strobes per score point while running.
- `LEVEL_STEP`, 50: points per speed-level increment.
- `HOLD_MS`, 1000: lockout in OVER, in `tick_1ms` strobes, before a restart is accepted.
- `BUZZ_MS`, 200: buzzer pulse length, in `tick_1ms` strobes.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `tick_1ms` in 1: one-cycle strobe, once per millisecond.
- `key_ready` in 1: keypad key-valid level.
- `key_code` in 5: keypad code. Sampled only on the rising edge of `key_ready`.
- `pause_sw` in 1: debounced pause switch level.
- `collide` in 1: collision flag from the draw logic.
- `state` out 2: 0=IDLE, 1=RUN, 2=PAUSE, 3=OVER.
- `run_en` out 1: high only in RUN. Gates object motion.
- `clr_world` out 1: one-cycle pulse when a new game starts.
- `gameover` out 1: high in OVER.
- `score` out 16: 4-digit BCD, `score[15:12]` is the thousands digit.
- `speed_lvl` out 3: current speed level, 0..7.
- `buzz` out 1: buzzer drive, active-low (1 = silent).

## Operation
- Start press is defined as: rising edge of `key_ready` (registered previous value) AND `key_code == START_KEY`. A held key produces exactly one press.
- IDLE:
  - Start press -> RUN.
  - On entry to RUN: `clr_world` pulses; `score`, `speed_lvl` and the ms prescaler are cleared.
- RUN, in priority order:
  - `collide` -> OVER.
  - Otherwise `pause_sw` = 1 -> PAUSE.
  - Otherwise, each `tick_1ms` advances the prescaler. When it reaches `SCORE_MS`-1 it wraps to 0 and the score adds 1 in BCD.
  - BCD rules: a digit at 9 rolls to 0 and carries. The score saturates at 9999 and never wraps.
  - A binary point counter runs alongside the score. When it reaches `LEVEL_STEP` it resets to 0 and `speed_lvl` increments, saturating at 7.
- PAUSE:
  - Prescaler, score and level are frozen.
  - `collide` and key presses are ignored.
  - `pause_sw` = 0 -> RUN. No `clr_world` pulse on this transition.
- OVER:
  - Score and level are held for display.
  - The lockout counter loads `HOLD_MS` on entry and decrements on `tick_1ms`.
  - Start presses are ignored while the counter is non-zero.
  - After lockout, a start press -> RUN with the same clear behaviour as from IDLE.
- Simultaneous events:
  - Score tick and `collide` in the same cycle: the point is not awarded.
  - Pause and collide in the same cycle: OVER wins.
  - A press arriving in IDLE in the same cycle as a `tick_1ms` is accepted.
- Reset (`rstn` = 0 on a clock edge), including mid-game, forces:
  - `state` = IDLE, `run_en` = 0, `clr_world` = 0, `gameover` = 0.
  - `score` = 0, `speed_lvl` = 0, `buzz` = 1.
  - All internal counters and the key edge register = 0.

## Timing
- Every output is registered.
- A qualifying input sampled at edge N is reflected at edge N+1: `state`, `run_en`, `gameover` and `clr_world` all update on the same edge.
- `clr_world` is high for exactly one cycle.
- A `score` increment appears one cycle after the wrapping `tick_1ms`. A level-up appears on the same edge as the score update that causes it.
- Key press latency: press detected at edge N (`key_ready` rises) -> RUN at edge N+1.
- Lockout: a press is accepted no earlier than `HOLD_MS` ticks after entry to OVER.

## Configuration
- `GAME_SEQ_BUZZ_EN` defined:
  - `buzz` goes low for `BUZZ_MS` ticks on entry to OVER, and on each `speed_lvl` increment.
  - A new trigger during an active pulse restarts the pulse counter.
- `GAME_SEQ_BUZZ_EN` undefined: `buzz` is tied to 1 and no buzzer counter is synthesized.

## Test plan
- Reset then start: reset then release `rstn`; raise `key_ready` with code 5'h10 -> next cycle `state` = 1, `run_en` = 1, one-cycle `clr_world`. Hold the key for 50 cycles -> no second `clr_world`.
- Scoring and level: 1000 `tick_1ms` strobes in RUN with `SCORE_MS` = 100 -> `score` = 16'h0010. With `LEVEL_STEP` = 5 -> `speed_lvl` = 2.
- BCD carry and saturation: preload to 0099 via ticks -> next point gives 16'h0100. Drive to 9999 -> further ticks keep 16'h9999.
- Pause: `pause_sw` = 1 for 500 ticks -> `score` unchanged, `collide` ignored. `pause_sw` = 0 -> RUN, no `clr_world`.
- Game over: `collide` and `pause_sw` rise in the same cycle as a score tick -> `state` = 3, `gameover` = 1, point not added.
  - A start press at tick 999 after entry -> ignored.
  - A start press at tick 1000 -> RUN with `score` = 0.
  - With `GAME_SEQ_BUZZ_EN`: `buzz` = 0 for 200 ticks after OVER entry.
- Mid-game reset: `rstn` = 0 for one cycle during RUN with `score` = 0042 -> IDLE, `score` = 0, `buzz` = 1.

Source files
------------

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - Runner game-flow controller: IDLE/RUN/PAUSE/OVER, BCD score, speed level, buzzer
//
// Converts keypad start presses, the pause switch and the draw-logic collision
// flag into a run enable and a one-cycle world-clear pulse. It keeps a 4-digit
// BCD score, which saturates at 9999, and a 0..7 speed level.
//
// Optional feature macro: GAME_SEQ_BUZZ_EN. When it is defined, buzz pulses low
// on entry to OVER and on each level-up. When it is undefined, buzz is tied to 1.
//
// Ports:
//   clk, rstn          clock; synchronous active-low reset
//   tick_1ms           one-cycle millisecond strobe
//   key_ready/key_code keypad valid level and code (code sampled on the ready rising edge)
//   pause_sw           debounced pause switch
//   collide            collision flag from the draw logic
//   state              0=IDLE 1=RUN 2=PAUSE 3=OVER
//   run_en, gameover   high in RUN / OVER respectively
//   clr_world          one-cycle pulse when a new game starts
//   score              4-digit BCD score
//   speed_lvl          speed level 0..7
//   buzz               buzzer drive, active-low
module game_sequencer #(
    parameter logic [4:0] START_KEY  = 5'h10,
    parameter int         SCORE_MS   = 100,
    parameter int         LEVEL_STEP = 50,
    parameter int         HOLD_MS    = 1000,
    parameter int         BUZZ_MS    = 200
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tick_1ms,
    input  logic        key_ready,
    input  logic [4:0]  key_code,
    input  logic        pause_sw,
    input  logic        collide,
    output logic [1:0]  state,
    output logic        run_en,
    output logic        clr_world,
    output logic        gameover,
    output logic [15:0] score,
    output logic [2:0]  speed_lvl,
    output logic        buzz
);

    localparam int PRE_W  = $clog2(SCORE_MS + 1);
    localparam int PTS_W  = $clog2(LEVEL_STEP + 1);
    localparam int HOLD_W = $clog2(HOLD_MS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t              st;
    logic                key_prev;
    logic [PRE_W-1:0]    pre;
    logic [PTS_W-1:0]    pts;
    logic [HOLD_W-1:0]   hold;

    logic start_press;
    logic do_start;
    logic score_tick;
    logic award;
    logic pts_wrap;
    logic lvl_up;

    function automatic logic [15:0] bcd_next(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A held key gives exactly one press: only the 0->1 transition of key_ready counts.
    assign start_press = key_ready & ~key_prev & (key_code == START_KEY);
    assign do_start    = start_press & ((st == S_IDLE) | ((st == S_OVER) & (hold == '0)));

    // Collision and pause both pre-empt the score tick in RUN, so a point coinciding
    // with either is dropped.
    assign score_tick = (st == S_RUN) & ~collide & ~pause_sw & tick_1ms
                        & (pre == PRE_W'(SCORE_MS - 1));
    assign award      = score_tick & (score != 16'h9999);
    assign pts_wrap   = award & (pts == PTS_W'(LEVEL_STEP - 1));
    assign lvl_up     = pts_wrap & (speed_lvl != 3'd7);

    assign state = st;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st        <= S_IDLE;
            key_prev  <= 1'b0;
            pre       <= '0;
            pts       <= '0;
            hold      <= '0;
            run_en    <= 1'b0;
            clr_world <= 1'b0;
            gameover  <= 1'b0;
            score     <= 16'h0000;
            speed_lvl <= 3'd0;
        end else begin
            key_prev  <= key_ready;
            clr_world <= 1'b0;
            if (do_start) begin
                st        <= S_RUN;
                run_en    <= 1'b1;
                gameover  <= 1'b0;
                clr_world <= 1'b1;
                score     <= 16'h0000;
                speed_lvl <= 3'd0;
                pre       <= '0;
                pts       <= '0;
                hold      <= '0;
            end else begin
                case (st)
                    S_RUN: begin
                        if (collide) begin
                            st       <= S_OVER;
                            run_en   <= 1'b0;
                            gameover <= 1'b1;
                            hold     <= HOLD_W'(HOLD_MS);
                        end else if (pause_sw) begin
                            st     <= S_PAUSE;
                            run_en <= 1'b0;
                        end else if (tick_1ms) begin
                            if (pre == PRE_W'(SCORE_MS - 1)) begin
                                pre <= '0;
                            end else begin
                                pre <= pre + PRE_W'(1);
                            end
                            // Points stop counting once the score is pinned at 9999.
                            if (award) begin
                                score <= bcd_next(score);
                                if (pts_wrap) begin
                                    pts <= '0;
                                end else begin
                                    pts <= pts + PTS_W'(1);
                                end
                                if (lvl_up) begin
                                    speed_lvl <= speed_lvl + 3'd1;
                                end
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!pause_sw) begin
                            st     <= S_RUN;
                            run_en <= 1'b1;
                        end
                    end
                    S_OVER: begin
                        if (tick_1ms && hold != '0) begin
                            hold <= hold - HOLD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef GAME_SEQ_BUZZ_EN
    localparam int BUZZ_W = $clog2(BUZZ_MS + 1);

    logic [BUZZ_W-1:0] buzz_cnt;
    logic              buzz_trig;

    assign buzz_trig = ((st == S_RUN) & collide) | lvl_up;

    // A retrigger reloads the counter, so the pulse stretches instead of stacking.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            buzz_cnt <= '0;
            buzz     <= 1'b1;
        end else if (buzz_trig) begin
            buzz_cnt <= BUZZ_W'(BUZZ_MS);
            buzz     <= (BUZZ_MS == 0);
        end else if (tick_1ms && buzz_cnt != '0) begin
            buzz_cnt <= buzz_cnt - BUZZ_W'(1);
            buzz     <= (buzz_cnt == BUZZ_W'(1));
        end
    end
`else
    assign buzz = 1'b1;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized self-checking bench for game_sequencer against a tick-count reference model
module tb_game_sequencer;

    localparam int SM = 2;
    localparam int LS = 5;
    localparam int HM = 20;
    localparam int BM = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tick_1ms = 1'b0;
    logic        key_ready = 1'b0;
    logic [4:0]  key_code = 5'h00;
    logic        pause_sw = 1'b0;
    logic        collide = 1'b0;
    logic [1:0]  state;
    logic        run_en;
    logic        clr_world;
    logic        gameover;
    logic [15:0] score;
    logic [2:0]  speed_lvl;
    logic        buzz;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the score is derived from the count of RUN ticks rather than a BCD counter.
    int m_state, m_ticks_run, m_over_ticks, m_buzz_left;
    bit m_kprev, m_clr;

    game_sequencer #(
        .START_KEY (5'h10),
        .SCORE_MS  (SM),
        .LEVEL_STEP(LS),
        .HOLD_MS   (HM),
        .BUZZ_MS   (BM)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .tick_1ms (tick_1ms),
        .key_ready(key_ready),
        .key_code (key_code),
        .pause_sw (pause_sw),
        .collide  (collide),
        .state    (state),
        .run_en   (run_en),
        .clr_world(clr_world),
        .gameover (gameover),
        .score    (score),
        .speed_lvl(speed_lvl),
        .buzz     (buzz)
    );

    always #5 clk = ~clk;

    function automatic int m_points();
        int p;
        p = m_ticks_run / SM;
        return (p > 9999) ? 9999 : p;
    endfunction

    function automatic int m_lvl();
        int l;
        l = m_points() / LS;
        return (l > 7) ? 7 : l;
    endfunction

    function automatic logic [15:0] m_score();
        int p;
        p = m_points();
        return 16'((p / 1000) * 4096 + ((p / 100) % 10) * 256 + ((p / 10) % 10) * 16 + (p % 10));
    endfunction

    function automatic logic m_buzz();
`ifdef GAME_SEQ_BUZZ_EN
        return (m_buzz_left == 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [26:0] m_outs();
        return {2'(m_state), m_state == 1, m_clr, m_state == 3, m_score(), 3'(m_lvl()), m_buzz()};
    endfunction

    // Advance the model with the inputs currently driven, then clock the DUT.
    task automatic step();
        bit press, trig;
        int old_lvl;
        trig = 0;
        if (!rstn) begin
            m_state = 0; m_ticks_run = 0; m_over_ticks = 0; m_buzz_left = 0;
            m_kprev = 0; m_clr = 0;
        end else begin
            press   = key_ready && !m_kprev && key_code == 5'h10;
            m_kprev = key_ready;
            m_clr   = 0;
            case (m_state)
                0: if (press) begin m_state = 1; m_clr = 1; m_ticks_run = 0; end
                1: begin
                    if (collide) begin
                        m_state = 3; m_over_ticks = 0; trig = 1;
                    end else if (pause_sw) begin
                        m_state = 2;
                    end else if (tick_1ms) begin
                        old_lvl = m_lvl();
                        m_ticks_run++;
                        if (m_lvl() > old_lvl) trig = 1;
                    end
                end
                2: if (!pause_sw) m_state = 1;
                default: begin
                    if (press && m_over_ticks >= HM) begin
                        m_state = 1; m_clr = 1; m_ticks_run = 0;
                    end else if (tick_1ms) begin
                        m_over_ticks++;
                    end
                end
            endcase
            if (trig) m_buzz_left = BM;
            else if (tick_1ms && m_buzz_left > 0) m_buzz_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step(); step();
        vectors += 7;
        if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
        if (run_en !== 1'b0) begin miscompares++; $display("FAIL reset_run_en: got %b expected 0", run_en); end
        if (clr_world !== 1'b0) begin miscompares++; $display("FAIL reset_clr: got %b expected 0", clr_world); end
        if (gameover !== 1'b0) begin miscompares++; $display("FAIL reset_gameover: got %b expected 0", gameover); end
        if (score !== 16'h0000) begin miscompares++; $display("FAIL reset_score: got %h expected 0000", score); end
        if (speed_lvl !== 3'd0) begin miscompares++; $display("FAIL reset_lvl: got %0d expected 0", speed_lvl); end
        if (buzz !== 1'b1) begin miscompares++; $display("FAIL reset_buzz: got %b expected 1", buzz); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_start();
        key_code = 5'h10; key_ready = 1'b1;
        step();
        vectors += 3;
        if (state !== 2'd1) begin miscompares++; $display("FAIL start_state: got %0d expected 1", state); end
        if (run_en !== 1'b1) begin miscompares++; $display("FAIL start_run_en: got %b expected 1", run_en); end
        if (clr_world !== 1'b1) begin miscompares++; $display("FAIL start_clr: got %b expected 1", clr_world); end
        for (int i = 0; i < 50; i++) begin
            tick_1ms = ($urandom_range(0, 1) == 1);
            step();
            vectors++;
            if (clr_world !== 1'b0 || state !== 2'd1) begin
                miscompares++;
                $display("FAIL held_key: clr=%b state=%0d expected clr=0 state=1", clr_world, state);
            end
        end
        key_ready = 1'b0; tick_1ms = 1'b0;
        step();
    endtask

    task automatic test_scoring();
        for (int i = 0; i < 120; i++) begin
            tick_1ms = ($urandom_range(0, 2) != 0);
            step();
            vectors++;
            if (score !== m_score() || speed_lvl !== 3'(m_lvl())) begin
                miscompares++;
                $display("FAIL scoring: score=%h lvl=%0d expected score=%h lvl=%0d", score, speed_lvl, m_score(), m_lvl());
            end
        end
        tick_1ms = 1'b0;
    endtask

    task automatic test_pause();
        logic [15:0] held;
        held = score;
        pause_sw = 1'b1;
        step();
        for (int i = 0; i < 100; i++) begin
            tick_1ms = $urandom_range(0, 1);
            collide  = ($urandom_range(0, 3) == 0);
            key_ready = $urandom_range(0, 1);
            step();
            vectors++;
            if (state !== 2'd2 || score !== held || run_en !== 1'b0) begin
                miscompares++;
                $display("FAIL pause_hold: state=%0d score=%h run_en=%b expected 2 %h 0", state, score, run_en, held);
            end
        end
        pause_sw = 1'b0; collide = 1'b0; tick_1ms = 1'b0; key_ready = 1'b0;
        step();
        vectors++;
        if (state !== 2'd1 || clr_world !== 1'b0 || run_en !== 1'b1) begin
            miscompares++;
            $display("FAIL unpause: state=%0d clr=%b run_en=%b expected 1 0 1", state, clr_world, run_en);
        end
    endtask

    task automatic test_gameover();
        logic [15:0] held;
        while (m_ticks_run % SM != SM - 1) begin tick_1ms = 1'b1; step(); end
        tick_1ms = 1'b0; step();
        held = score;
        tick_1ms = 1'b1; collide = 1'b1; pause_sw = 1'b1;
        step();
        collide = 1'b0; pause_sw = 1'b0; tick_1ms = 1'b0;
        vectors += 3;
        if (state !== 2'd3) begin miscompares++; $display("FAIL over_state: got %0d expected 3", state); end
        if (gameover !== 1'b1 || run_en !== 1'b0) begin miscompares++; $display("FAIL over_flags: gameover=%b run_en=%b expected 1 0", gameover, run_en); end
        if (score !== held) begin miscompares++; $display("FAIL over_no_point: got %h expected %h", score, held); end
        for (int i = 0; i < HM - 1; i++) begin
            tick_1ms = 1'b1;
            step();
            vectors++;
            if (buzz !== m_buzz()) begin miscompares++; $display("FAIL over_buzz: got %b expected %b", buzz, m_buzz()); end
        end
        tick_1ms = 1'b0; key_code = 5'h10; key_ready = 1'b1;
        step();
        vectors++;
        if (state !== 2'd3) begin miscompares++; $display("FAIL lockout_early: got %0d expected 3", state); end
        key_ready = 1'b0; tick_1ms = 1'b1;
        step();
        tick_1ms = 1'b0; key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        vectors += 3;
        if (state !== 2'd1) begin miscompares++; $display("FAIL lockout_done: got %0d expected 1", state); end
        if (score !== 16'h0000) begin miscompares++; $display("FAIL restart_score: got %h expected 0000", score); end
        if (clr_world !== 1'b1) begin miscompares++; $display("FAIL restart_clr: got %b expected 1", clr_world); end
    endtask

    task automatic test_bcd_saturation();
        bit seen100;
        seen100 = 0;
        tick_1ms = 1'b1;
        for (int i = 0; i < SM * 9999 + 20; i++) begin
            step();
            vectors++;
            if (score !== m_score() || speed_lvl !== 3'(m_lvl())) begin
                miscompares++;
                $display("FAIL bcd_run: score=%h lvl=%0d expected %h %0d", score, speed_lvl, m_score(), m_lvl());
            end
            if (!seen100 && m_points() == 100) begin
                seen100 = 1;
                vectors++;
                if (score !== 16'h0100) begin miscompares++; $display("FAIL bcd_carry: got %h expected 0100", score); end
            end
        end
        tick_1ms = 1'b0;
        vectors += 2;
        if (score !== 16'h9999) begin miscompares++; $display("FAIL bcd_sat: got %h expected 9999", score); end
        if (speed_lvl !== 3'd7) begin miscompares++; $display("FAIL lvl_sat: got %0d expected 7", speed_lvl); end
    endtask

    task automatic test_midgame_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        vectors += 4;
        if (state !== 2'd0) begin miscompares++; $display("FAIL midreset_state: got %0d expected 0", state); end
        if (score !== 16'h0000) begin miscompares++; $display("FAIL midreset_score: got %h expected 0000", score); end
        if (buzz !== 1'b1) begin miscompares++; $display("FAIL midreset_buzz: got %b expected 1", buzz); end
        if (run_en !== 1'b0) begin miscompares++; $display("FAIL midreset_run_en: got %b expected 0", run_en); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            tick_1ms = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) key_ready = ~key_ready;
            key_code = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'h10;
            if ($urandom_range(0, 29) == 0) pause_sw = ~pause_sw;
            collide = ($urandom_range(0, 59) == 0);
            rstn = ($urandom_range(0, 799) != 0);
            step();
            vectors++;
            if ({state, run_en, clr_world, gameover, score, speed_lvl, buzz} !== m_outs()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", i,
                         {state, run_en, clr_world, gameover, score, speed_lvl, buzz}, m_outs());
            end
        end
        rstn = 1'b1; collide = 1'b0; pause_sw = 1'b0; key_ready = 1'b0; tick_1ms = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_scoring();
        test_pause();
        test_gameover();
        test_bcd_saturation();
        test_midgame_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
